// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the UART receive path.
//   uart_state_t : receiver FSM state encoding
//   LINE_IDLE    : level of the serial line when no frame is in flight
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } uart_state_t;

    localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/uart_rx_buf.sv
// uart_rx_buf
// Small circular buffer for received words with a registered head output.
// Parameters:
//   WIDTH : word width
//   DEPTH : number of entries (power of 2, >= 2)
// Ports:
//   clk    : clock
//   reset_ : synchronous active-low reset (empties buffer, clears dout)
//   push   : write din (ignored when full unless pop happens in the same clk)
//   din    : word to write
//   pop    : remove head entry (ignored when empty)
//   dout   : head entry, holds its last value while the buffer is empty
//   full   : all entries occupied
//   empty  : no entries occupied
module uart_rx_buf #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_n;
    logic [WIDTH-1:0] head_n;
    logic             do_push;
    logic             do_pop;

    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));

    // A push into a full buffer is accepted only when an entry leaves in the same clk.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        count_n = count;
        if (do_push && !do_pop) begin
            count_n = count + 1'b1;
        end else if (do_pop && !do_push) begin
            count_n = count - 1'b1;
        end
    end

    // The head register must already show the new front entry after the update,
    // including the case where that entry is the word being written this clk.
    always_comb begin
        head_n = dout;
        if (count_n != '0) begin
            if (do_pop) begin
                if (count == CNT_W'(1)) begin
                    head_n = din;
                end else begin
                    head_n = mem[PTR_W'(rd_ptr + 1'b1)];
                end
            end else if (count == '0) begin
                head_n = din;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of 2.
    always_ff @(posedge clk) begin
        if (!reset_) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            dout   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= PTR_W'(wr_ptr + 1'b1);
            end
            if (do_pop) begin
                rd_ptr <= PTR_W'(rd_ptr + 1'b1);
            end
            count <= count_n;
            dout  <= head_n;
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
// UART receiver with oversampled bit recovery and a received-word buffer.
// Optional feature: define UART_RX_PARITY_EN to check one even-parity bit
// after the data bits; without it the frame goes straight from data to stop.
// Parameters:
//   DATA_BITS  : data bits per frame (5..9)
//   OVERSAMPLE : sample ticks per bit (even, >= 4)
//   CLK_DIV    : clk cycles per sample tick (>= 1)
//   STOP_BITS  : stop bits checked per frame (1 or 2)
//   FIFO_DEPTH : received-word buffer depth (power of 2, >= 2)
// Ports:
//   clk            : single clock
//   reset_         : synchronous active-low reset
//   serial_in      : asynchronous serial line, idle high
//   host_not_ready : host back-pressure, blocks pops while high
//   rx_datareg     : head-of-buffer word
//   rx_handshake   : buffer not empty (rx_datareg valid)
//   error1         : framing/parity error pulse
//   error2         : overrun pulse (word dropped, buffer full)
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 8,
    parameter int CLK_DIV    = 4,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset_,
    input  logic                 serial_in,
    input  logic                 host_not_ready,
    output logic [DATA_BITS-1:0] rx_datareg,
    output logic                 rx_handshake,
    output logic                 error1,
    output logic                 error2
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int OS_W  = $clog2(OVERSAMPLE);
    localparam int BIT_W = $clog2(DATA_BITS + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0]  OS_HALF  = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] STP_LAST = BIT_W'(STOP_BITS - 1);

    logic sync1;
    logic sync2;
    logic rx_prev;
    logic rx_s;
    logic start_edge;

    logic [DIV_W-1:0] div_cnt;
    logic             tick;

    uart_state_t          state,      state_n;
    logic [OS_W-1:0]      os_cnt,     os_n;
    logic [BIT_W-1:0]     bit_cnt,    bit_n;
    logic [DATA_BITS-1:0] shift_r,    shift_n;
    logic                 frame_bad,  frame_bad_n;
    logic                 stop_bad,   stop_bad_n;
    logic                 push_req;
    logic                 err1_req;

    logic push_q;
    logic pop;
    logic buf_full;
    logic buf_empty;

    assign rx_s = sync2;

    // rx_prev is one clk older than rx_s so a high->low step of the
    // synchronized line can be seen as a start edge.
    always_ff @(posedge clk) begin
        if (!reset_) begin
            sync1   <= LINE_IDLE;
            sync2   <= LINE_IDLE;
            rx_prev <= LINE_IDLE;
        end else begin
            sync1   <= serial_in;
            sync2   <= sync1;
            rx_prev <= sync2;
        end
    end

    assign start_edge = (state == ST_IDLE) && (rx_prev == LINE_IDLE) && (rx_s != LINE_IDLE);

    // Restarting the divider on the start edge aligns every later tick to the
    // frame, so tick OVERSAMPLE/2 lands in the middle of the start bit.
    always_ff @(posedge clk) begin
        if (!reset_) begin
            div_cnt <= '0;
        end else if (start_edge || div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign tick = (div_cnt == DIV_LAST) && !start_edge;

    always_ff @(posedge clk) begin
        if (!reset_) begin
            state     <= ST_IDLE;
            os_cnt    <= '0;
            bit_cnt   <= '0;
            shift_r   <= '0;
            frame_bad <= 1'b0;
            stop_bad  <= 1'b0;
            push_q    <= 1'b0;
            error1    <= 1'b0;
        end else begin
            state     <= state_n;
            os_cnt    <= os_n;
            bit_cnt   <= bit_n;
            shift_r   <= shift_n;
            frame_bad <= frame_bad_n;
            stop_bad  <= stop_bad_n;
            push_q    <= push_req;
            error1    <= err1_req;
        end
    end

    // os_cnt counts ticks inside the current bit; bit_cnt counts data bits,
    // then is reused to count stop bits.
    always_comb begin
        state_n     = state;
        os_n        = os_cnt;
        bit_n       = bit_cnt;
        shift_n     = shift_r;
        frame_bad_n = frame_bad;
        stop_bad_n  = stop_bad;
        push_req    = 1'b0;
        err1_req    = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start_edge) begin
                    state_n     = ST_START;
                    os_n        = '0;
                    bit_n       = '0;
                    frame_bad_n = 1'b0;
                    stop_bad_n  = 1'b0;
                end
            end

            ST_START: begin
                if (tick) begin
                    if (os_cnt == OS_HALF) begin
                        os_n  = '0;
                        bit_n = '0;
                        if (rx_s == LINE_IDLE) begin
                            state_n = ST_IDLE;
                        end else begin
                            state_n = ST_DATA;
                        end
                    end else begin
                        os_n = os_cnt + 1'b1;
                    end
                end
            end

            ST_DATA: begin
                if (tick) begin
                    if (os_cnt == OS_LAST) begin
                        os_n    = '0;
                        shift_n = {rx_s, shift_r[DATA_BITS-1:1]};
                        if (bit_cnt == BIT_LAST) begin
                            bit_n = '0;
`ifdef UART_RX_PARITY_EN
                            state_n = ST_PARITY;
`else
                            state_n = ST_STOP;
`endif
                        end else begin
                            bit_n = bit_cnt + 1'b1;
                        end
                    end else begin
                        os_n = os_cnt + 1'b1;
                    end
                end
            end

`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (tick) begin
                    if (os_cnt == OS_LAST) begin
                        os_n    = '0;
                        state_n = ST_STOP;
                        if (rx_s != ^shift_r) begin
                            err1_req    = 1'b1;
                            frame_bad_n = 1'b1;
                        end
                    end else begin
                        os_n = os_cnt + 1'b1;
                    end
                end
            end
`endif

            ST_STOP: begin
                if (tick) begin
                    if (os_cnt == OS_LAST) begin
                        os_n = '0;
                        if (bit_cnt == STP_LAST) begin
                            bit_n = '0;
                            if (stop_bad || rx_s != LINE_IDLE) begin
                                err1_req = 1'b1;
                                state_n  = ST_WAIT_IDLE;
                            end else begin
                                push_req = !frame_bad;
                                state_n  = ST_IDLE;
                            end
                        end else begin
                            bit_n      = bit_cnt + 1'b1;
                            stop_bad_n = stop_bad || (rx_s != LINE_IDLE);
                        end
                    end else begin
                        os_n = os_cnt + 1'b1;
                    end
                end
            end

            // A held-low line (break) must not look like a stream of new frames.
            ST_WAIT_IDLE: begin
                if (rx_s == LINE_IDLE) begin
                    state_n = ST_IDLE;
                end
            end

            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    assign rx_handshake = !buf_empty;
    assign pop          = rx_handshake && !host_not_ready;

    // The buffer drops a push when full without a pop; flag it here.
    always_ff @(posedge clk) begin
        if (!reset_) begin
            error2 <= 1'b0;
        end else begin
            error2 <= push_q && buf_full && !pop;
        end
    end

    uart_rx_buf #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_buf (
        .clk    (clk),
        .reset_ (reset_),
        .push   (push_q),
        .din    (shift_r),
        .pop    (pop),
        .dout   (rx_datareg),
        .full   (buf_full),
        .empty  (buf_empty)
    );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo
// Directed frames with a scoreboard queue of expected received words.
// Build with UART_RX_PARITY_EN defined to add the parity frames.
module tb_uart_rx_fifo;

    localparam int BIT_CLKS = 32;

    logic       clk = 1'b0;
    logic       reset_;
    logic       serial_in;
    logic       host_not_ready;
    logic [7:0] rx_datareg;
    logic       rx_handshake;
    logic       error1;
    logic       error2;

    int         checks = 0;
    int         errors = 0;
    int         err1_seen = 0;
    int         err2_seen = 0;
    int         exp_err1 = 0;
    int         exp_err2 = 0;
    logic [7:0] exp_q[$];

    uart_rx_fifo #(
        .DATA_BITS  (8),
        .OVERSAMPLE (8),
        .CLK_DIV    (4),
        .STOP_BITS  (1),
        .FIFO_DEPTH (4)
    ) dut (
        .clk            (clk),
        .reset_         (reset_),
        .serial_in      (serial_in),
        .host_not_ready (host_not_ready),
        .rx_datareg     (rx_datareg),
        .rx_handshake   (rx_handshake),
        .error1         (error1),
        .error2         (error2)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic driveBit(input logic b);
        serial_in = b;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    // Sends one frame; a bad stop bit is followed by a 100 clk break.
    task automatic applyStimulus(input logic [7:0] data, input bit stop_ok,
                                 input bit parity_ok, input bit expect_push);
        if (expect_push && stop_ok && parity_ok) exp_q.push_back(data);
        driveBit(1'b0);
        for (int i = 0; i < 8; i++) driveBit(data[i]);
`ifdef UART_RX_PARITY_EN
        driveBit(parity_ok ? ^data : ~^data);
`endif
        driveBit(stop_ok);
        if (!stop_ok) begin
            serial_in = 1'b0;
            repeat (100) @(negedge clk);
        end
        serial_in = 1'b1;
        repeat (16) @(negedge clk);
    endtask

    // Monitor: counts error pulses and checks every popped word against the queue.
    initial begin
        logic [7:0] exp_word;
        forever begin
            @(negedge clk);
            #1;
            if (reset_) begin
                if (error1) err1_seen++;
                if (error2) err2_seen++;
                if (rx_handshake && !host_not_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_word: got %0h expected none", rx_datareg);
                    end else begin
                        exp_word = exp_q.pop_front();
                        checkOutput("popped_word", int'(rx_datareg), int'(exp_word));
                    end
                end
            end
        end
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_         = 1'b0;
        serial_in      = 1'b1;
        host_not_ready = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        checkOutput("reset_datareg",  int'(rx_datareg),   0);
        checkOutput("reset_handshake", int'(rx_handshake), 0);
        checkOutput("reset_error1",   int'(error1),       0);
        checkOutput("reset_error2",   int'(error2),       0);
        @(negedge clk);
        reset_ = 1'b1;
        repeat (20) @(negedge clk);

        $display("[TB] frame 0xAA");
        applyStimulus(8'hAA, 1'b1, 1'b1, 1'b1);
        repeat (20) @(negedge clk);
        #1;
        checkOutput("hold_datareg_aa", int'(rx_datareg), 8'hAA);
        checkOutput("empty_after_aa", int'(rx_handshake), 0);
        checkOutput("err1_after_aa", err1_seen, exp_err1);

        $display("[TB] frame 0x55 with bad stop and break");
        applyStimulus(8'h55, 1'b0, 1'b1, 1'b1);
        exp_err1++;
        repeat (40) @(negedge clk);
        checkOutput("err1_after_break", err1_seen, exp_err1);
        checkOutput("datareg_after_break", int'(rx_datareg), 8'hAA);

        $display("[TB] start glitch then frame 0x3C");
        serial_in = 1'b0;
        repeat (8) @(negedge clk);
        serial_in = 1'b1;
        repeat (64) @(negedge clk);
        checkOutput("err1_after_glitch", err1_seen, exp_err1);
        checkOutput("hs_after_glitch", int'(rx_handshake), 0);
        applyStimulus(8'h3C, 1'b1, 1'b1, 1'b1);
        repeat (20) @(negedge clk);

        $display("[TB] reset during data bit 4");
        driveBit(1'b0);
        for (int i = 0; i < 4; i++) driveBit(1'b0);
        serial_in = 1'b1;
        repeat (16) @(negedge clk);
        reset_ = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("midreset_datareg",  int'(rx_datareg),   0);
        checkOutput("midreset_handshake", int'(rx_handshake), 0);
        checkOutput("midreset_error1",   int'(error1),       0);
        @(negedge clk);
        reset_ = 1'b1;
        repeat (150) @(negedge clk);
        checkOutput("hs_after_midreset", int'(rx_handshake), 0);
        checkOutput("err1_after_midreset", err1_seen, exp_err1);
        applyStimulus(8'hF0, 1'b1, 1'b1, 1'b1);
        repeat (20) @(negedge clk);

        $display("[TB] overflow with host back-pressure");
        host_not_ready = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(8'(i), 1'b1, 1'b1, i <= 4);
        end
        exp_err2++;
        repeat (20) @(negedge clk);
        #1;
        checkOutput("err2_after_overflow", err2_seen, exp_err2);
        checkOutput("hs_while_full", int'(rx_handshake), 1);
        checkOutput("head_while_full", int'(rx_datareg), 8'h01);
        @(negedge clk);
        host_not_ready = 1'b0;
        repeat (20) @(negedge clk);
        checkOutput("hs_after_drain", int'(rx_handshake), 0);
        checkOutput("datareg_after_drain", int'(rx_datareg), 8'h04);

`ifdef UART_RX_PARITY_EN
        $display("[TB] parity frames 0x07");
        applyStimulus(8'h07, 1'b1, 1'b0, 1'b1);
        exp_err1++;
        repeat (20) @(negedge clk);
        checkOutput("err1_after_bad_parity", err1_seen, exp_err1);
        applyStimulus(8'h07, 1'b1, 1'b1, 1'b1);
        repeat (20) @(negedge clk);
`endif

        for (int n = 0; n < 200 && exp_q.size() != 0; n++) @(negedge clk);
        checkOutput("queue_drained", exp_q.size(), 0);
        checkOutput("err1_total", err1_seen, exp_err1);
        checkOutput("err2_total", err2_seen, exp_err2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, meaning data bits per frame (legal 5..9).
REQ-002 SHALL have parameter OVERSAMPLE, default 8, meaning sample ticks per bit (even, >=4).
REQ-003 SHALL have parameter CLK_DIV, default 4, meaning clk cycles per sample tick (>=1).
REQ-004 SHALL have parameter STOP_BITS, default 1, meaning stop bits checked per frame (1 or 2).
REQ-005 SHALL have parameter FIFO_DEPTH, default 4, meaning received-word buffer depth (power of 2, >=2).
REQ-006 SHALL have port clk  input  1  single clock for all logic.
REQ-007 SHALL have port reset_  input  1  reset, synchronous and active-low.
REQ-008 SHALL have port serial_in  input  1  asynchronous serial line, idle high.
REQ-009 SHALL have port host_not_ready  input  1  host back-pressure; pop is blocked while high.
REQ-010 SHALL have port rx_datareg  output  DATA_BITS  head-of-FIFO word.
REQ-011 SHALL have port rx_handshake  output  1  FIFO not empty (rx_datareg valid).
REQ-012 SHALL have port error1  output  1  framing-error pulse.
REQ-013 SHALL have port error2  output  1  overrun pulse.

Function
REQ-014 SHALL pass serial_in through a 2-flop synchronizer; all sampling uses the synchronized value.
REQ-015 SHALL generate a one-clk sample tick every CLK_DIV clks, counter free-running except restarted on start-edge detection.
REQ-016 SHALL implement states IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
REQ-017 IDLE->START on synchronized falling edge; START samples at tick OVERSAMPLE/2: low->DATA, high->IDLE (glitch, no error, no push).
REQ-018 DATA SHALL sample every OVERSAMPLE ticks at mid-bit, LSB first, for DATA_BITS bits, then ->PARITY or STOP.
REQ-019 STOP SHALL sample STOP_BITS mid-bit values; all high -> push word, ->IDLE; any low -> error1 pulse one clk, word discarded, ->WAIT_IDLE.
REQ-020 WAIT_IDLE SHALL hold until synchronized line is high, then ->IDLE (break condition produces exactly one error1).
REQ-021 Push SHALL occur one clk after the final stop-bit sample; rx_handshake rises the clk after push.
REQ-022 Pop SHALL occur on any clk with rx_handshake=1 and host_not_ready=0; rx_datareg shows next entry the following clk.
REQ-023 Push into a full FIFO without simultaneous pop SHALL drop the new word and pulse error2 one clk; contents unchanged.
REQ-024 Simultaneous push and pop when full SHALL both succeed with no error2.
REQ-025 FIFO pointers SHALL wrap modulo FIFO_DEPTH; an occupancy counter of width clog2(FIFO_DEPTH)+1 SHALL distinguish full from empty.
REQ-026 rx_datareg SHALL hold its last value while empty.

Reset
REQ-027 With reset_=0 at a clk edge: state IDLE, FIFO empty, rx_datareg=0, rx_handshake=0, error1=0, error2=0, synchronizer flops=1, tick counter=0.
REQ-028 Reset mid-frame SHALL abort the frame with no push and no error pulse.

Configuration
REQ-029 With UART_RX_PARITY_EN defined, PARITY state SHALL sample one even-parity bit after data; mismatch SHALL discard the word and pulse error1, then continue to STOP checking.
REQ-030 Without UART_RX_PARITY_EN, PARITY state and logic SHALL be absent; DATA goes directly to STOP.

Structure
REQ-031 Shared package uart_pkg SHALL hold the state encoding constants and the idle-line level constant.
REQ-032 Buffer SHALL be a sub-module uart_rx_buf (parameterised width/depth, push/pop/full/empty).

Verification (DATA_BITS=8, OVERSAMPLE=8, CLK_DIV=4, 32 clk/bit)
REQ-033 Frame 0xAA, good stop -> rx_datareg=0xAA, rx_handshake=1 at clk 1 after push, no errors.
REQ-034 Stop bit driven low for 0x55 -> error1 single pulse, no push; line then held low 100 clk -> no further error1.
REQ-035 host_not_ready=1, send 5 frames 0x01..0x05 -> first 4 buffered, error2 pulse on 5th; release -> pops 0x01..0x04 in order.
REQ-036 Start glitch low 8 clk -> no push, no error, next valid frame 0x3C received.
REQ-037 reset_=0 during DATA bit 4 -> outputs at reset values, next frame 0xF0 received correctly.
REQ-038 With UART_RX_PARITY_EN, frame 0x07 with wrong parity -> error1, no push; correct parity -> 0x07 pushed.
